dtcm_ctrl: RTL
==============

DTCM_CTRL -- requirements
Module: dtcm_ctrl

Interface
REQ-001 The block SHALL use the global defines `XLEN` (32, data width) and `DTCM_ADDR_WIDTH` (byte address width, 16) with no local parameters.
REQ-002 clk  input  1  single clock; every register is updated on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 dtcm_cmd_valid  input  1  command request from the LSU.
REQ-005 dtcm_cmd_ready  output  1  block can accept a command.
REQ-006 dtcm_cmd_read  input  1  1=load, 0=store.
REQ-007 dtcm_cmd_addr  input  DTCM_ADDR_WIDTH  byte address; bits [1:0] ignored.
REQ-008 dtcm_cmd_wdata  input  XLEN  store data.
REQ-009 dtcm_cmd_wmask  input  XLEN/8  store byte enables.
REQ-010 dtcm_rsp_valid  output  1  response available.
REQ-011 dtcm_rsp_ready  input  1  LSU accepts the response.
REQ-012 dtcm_rsp_rdata  output  XLEN  load data; 0 for stores.
REQ-013 ram_cs  output  1  SRAM chip select.
REQ-014 ram_we  output  1  SRAM write enable.
REQ-015 ram_addr  output  DTCM_ADDR_WIDTH-2  SRAM word address.
REQ-016 ram_wem  output  XLEN/8  SRAM byte write enables.
REQ-017 ram_din  output  XLEN  SRAM write data.
REQ-018 ram_dout  input  XLEN  SRAM read data; valid for exactly the cycle after a read with ram_cs=1 and ram_we=0; undefined otherwise.

Function
REQ-019 The FSM SHALL have 3 states: IDLE (no response pending), RSP (first response cycle, data taken from ram_dout), and HOLD (response stalled, data taken from the hold register).
REQ-020 dtcm_cmd_ready SHALL equal (state==IDLE) | (state!=IDLE & dtcm_rsp_ready), so back-to-back commands are accepted at one per cycle.
REQ-021 Accept (dtcm_cmd_valid & dtcm_cmd_ready) SHALL drive, combinationally in the same cycle: ram_cs=1, ram_we=~dtcm_cmd_read, ram_addr=dtcm_cmd_addr[DTCM_ADDR_WIDTH-1:2], ram_wem=dtcm_cmd_wmask & {XLEN/8{~dtcm_cmd_read}}, ram_din=dtcm_cmd_wdata.
REQ-022 Without an accept, ram_cs, ram_we and ram_wem SHALL be 0.
REQ-023 Without an accept, ram_addr and ram_din are don't-care but SHALL be driven 0.
REQ-024 Response latency SHALL be exactly 1 cycle: an accept in cycle N causes the FSM to be in RSP with dtcm_rsp_valid=1 in cycle N+1.
REQ-025 dtcm_rsp_valid SHALL be 1 in RSP and HOLD and 0 in IDLE.
REQ-026 A registered read flag SHALL record the command type; dtcm_rsp_rdata SHALL be ram_dout in RSP for reads, the hold register in HOLD for reads, and 0 for stores.
REQ-027 RSP & ~dtcm_rsp_ready SHALL capture ram_dout (reads only) into the hold register and move to HOLD.
REQ-028 HOLD SHALL keep dtcm_rsp_valid and dtcm_rsp_rdata stable until a handshake.
REQ-029 While in HOLD, ram_cs SHALL stay 0 unless a new command is accepted in the handshake cycle.
REQ-030 A response handshake with a simultaneous new accept SHALL go to RSP.
REQ-031 A response handshake without a new accept SHALL go to IDLE.
REQ-032 A store with wmask=0 SHALL still assert ram_cs=1, ram_we=1, ram_wem=0 and return a response.
REQ-033 Read-after-write to the same word in consecutive cycles SHALL return the new data; this relies on SRAM write-before-next-read ordering, and no forwarding logic is required.
REQ-034 The response order SHALL equal the command order, with at most one response outstanding.

Reset
REQ-035 Asserting rst_n=0 at any time, including mid-response, SHALL force: state=IDLE, dtcm_rsp_valid=0, read flag=0, hold register=0.
REQ-036 During reset, outputs SHALL be: dtcm_cmd_ready=1 (IDLE), ram_cs=0, ram_we=0, ram_wem=0.
REQ-037 A pending response SHALL be discarded by reset and never reported.
REQ-038 The first accept after reset release SHALL behave as in REQ-021.

Verification
REQ-039 Store then load: store addr 0x0010, wdata 0xDEADBEEF, wmask 4'hF; then load 0x0010 with rsp_ready=1 -> ram_addr=0x004 on both; responses in N+1 and N+2; load rdata=0xDEADBEEF; store rdata=0.
REQ-040 Partial store: memory word 0x11223344, store wdata 0xAABBCCDD, wmask 4'b0101, then load -> rdata=0x11BB33DD.
REQ-041 Back-pressure: load returning 0x12345678 with rsp_ready=0 for 3 cycles, ram_dout set to 0xFFFFFFFF after the first cycle -> rsp_valid held 1 with rdata=0x12345678 all 3 cycles; cmd_ready=0; ram_cs=0; release -> handshake, IDLE.
REQ-042 Streaming: 8 back-to-back loads with valid=1 and rsp_ready=1 -> cmd_ready constantly 1; one response per cycle, in order, 1-cycle latency.
REQ-043 Reset mid-operation: rst_n=0 while in HOLD -> rsp_valid=0 asynchronously; after release cmd_ready=1 and no stale response.
REQ-044 Address LSBs: load with addr 0x0013 -> ram_addr=0x004, identical to addr 0x0010.

Source files
------------

// File: rtl/dtcm_ctrl.sv
// dtcm_ctrl: data tightly-coupled memory controller.
// Bridges the LSU command/response handshake onto a single-port synchronous
// SRAM with one-cycle read latency. At most one response is outstanding; a
// response stalled by the LSU is parked in a hold register so the SRAM read
// port is free to change underneath it.

`timescale 1ns/1ps

`ifndef XLEN
`define XLEN 32
`endif
`ifndef DTCM_ADDR_WIDTH
`define DTCM_ADDR_WIDTH 16
`endif

module dtcm_ctrl (
    input  logic                          clk,
    input  logic                          rst_n,
    // LSU command channel
    input  logic                          dtcm_cmd_valid,
    output logic                          dtcm_cmd_ready,
    input  logic                          dtcm_cmd_read,
    input  logic [`DTCM_ADDR_WIDTH-1:0]   dtcm_cmd_addr,
    input  logic [`XLEN-1:0]              dtcm_cmd_wdata,
    input  logic [`XLEN/8-1:0]            dtcm_cmd_wmask,
    // LSU response channel
    output logic                          dtcm_rsp_valid,
    input  logic                          dtcm_rsp_ready,
    output logic [`XLEN-1:0]              dtcm_rsp_rdata,
    // SRAM port
    output logic                          ram_cs,
    output logic                          ram_we,
    output logic [`DTCM_ADDR_WIDTH-3:0]   ram_addr,
    output logic [`XLEN/8-1:0]            ram_wem,
    output logic [`XLEN-1:0]              ram_din,
    input  logic [`XLEN-1:0]              ram_dout
);

    // IDLE: nothing pending. RSP: first response cycle, data straight from
    // the SRAM. HOLD: response stalled, data from the hold register.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RSP  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic             read_reg, read_next;
    logic [`XLEN-1:0] hold_reg, hold_next;
    logic             accept;

    // Byte-offset bits of the address never reach the word-addressed SRAM.
    logic [1:0] unused_addr_lsb;
    assign unused_addr_lsb = dtcm_cmd_addr[1:0];

    // State, read flag and hold register; reset discards any pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            read_reg  <= 1'b0;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            read_reg  <= read_next;
            hold_reg  <= hold_next;
        end
    end

    // Next-state, handshake and SRAM drive logic.
    always_comb begin
        state_next     = state_reg;
        read_next      = read_reg;
        hold_next      = hold_reg;
        dtcm_cmd_ready = 1'b0;
        dtcm_rsp_valid = 1'b0;
        dtcm_rsp_rdata = '0;
        accept         = 1'b0;
        ram_cs         = 1'b0;
        ram_we         = 1'b0;
        ram_addr       = '0;
        ram_wem        = '0;
        ram_din        = '0;

        case (state_reg)
            IDLE: begin
                dtcm_cmd_ready = 1'b1;
            end
            RSP: begin
                dtcm_rsp_valid = 1'b1;
                dtcm_cmd_ready = dtcm_rsp_ready;
                if (read_reg) begin
                    dtcm_rsp_rdata = ram_dout;
                end
                // ram_dout is only valid this one cycle, so a stalled read
                // must be captured now.
                if (!dtcm_rsp_ready) begin
                    state_next = HOLD;
                    if (read_reg) begin
                        hold_next = ram_dout;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            HOLD: begin
                dtcm_rsp_valid = 1'b1;
                dtcm_cmd_ready = dtcm_rsp_ready;
                if (read_reg) begin
                    dtcm_rsp_rdata = hold_reg;
                end
                if (dtcm_rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Gating with rst_n keeps the SRAM quiet while reset is held even
        // though ready reads as 1 in IDLE.
        accept = dtcm_cmd_valid & dtcm_cmd_ready & rst_n;

        // A new command always lands in RSP next cycle, even when it
        // coincides with the handshake of the previous response.
        if (accept) begin
            state_next = RSP;
            read_next  = dtcm_cmd_read;
            ram_cs     = 1'b1;
            ram_we     = ~dtcm_cmd_read;
            ram_addr   = dtcm_cmd_addr[`DTCM_ADDR_WIDTH-1:2];
            ram_wem    = dtcm_cmd_wmask & {(`XLEN/8){~dtcm_cmd_read}};
            ram_din    = dtcm_cmd_wdata;
        end
    end

endmodule
